// File: rtl/knn_local_buf_scan_reader.sv
// Scan reader for a single-port local URAM buffer: issues back-to-back reads under a FIFO credit rule
// and streams the words out in order on valid/ready. Optional address wrap via KNN_SCAN_WRAP_EN.
module knn_local_buf_scan_reader #(
  parameter int DataWidth    = 256,
  parameter int AddressRange = 2048,
  parameter int AddressWidth = 11,
  parameter int ReadLatency  = 2,
  parameter int FifoDepth    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [AddressWidth-1:0] cmd_addr,
  input  logic [AddressWidth:0]   cmd_len,
  output logic [AddressWidth-1:0] address0,
  output logic                    ce0,
  output logic                    we0,
  output logic [DataWidth-1:0]    d0,
  input  logic [DataWidth-1:0]    q0,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DataWidth-1:0]    out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CW = $clog2(FifoDepth + ReadLatency + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [AddressWidth-1:0] addr_q;
  logic [AddressWidth-1:0] addr_next;
  logic [AddressWidth:0]   rem_q;
  logic                    err_q;
  logic                    cmd_fire;
  logic                    cmd_bad;
  logic                    issue;
  logic                    credit_ok;
  logic [CW-1:0]           inflight;

  logic [ReadLatency-1:0]  vld_p0;
  logic [ReadLatency-1:0]  last_p0;

  logic [DataWidth-1:0]    fifo_data_p1 [FifoDepth];
  logic                    fifo_last_p1 [FifoDepth];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_cnt;
  logic                    push, pop;

  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && err_q;
  assign we0       = 1'b0;
  assign d0        = '0;
  assign address0  = addr_q;

`ifdef KNN_SCAN_WRAP_EN
  assign cmd_bad   = ({1'b0, cmd_addr} >= (AddressWidth+1)'(AddressRange)) ||
                     (cmd_len > (AddressWidth+1)'(AddressRange));
  assign addr_next = (addr_q == AddressWidth'(AddressRange - 1)) ? '0 : addr_q + 1'b1;
`else
  logic [AddressWidth+1:0] end_addr;
  assign end_addr  = {2'b00, cmd_addr} + {1'b0, cmd_len};
  assign cmd_bad   = ({1'b0, cmd_addr} >= (AddressWidth+1)'(AddressRange)) ||
                     (end_addr > (AddressWidth+2)'(AddressRange));
  assign addr_next = addr_q + 1'b1;
`endif

  // Credit counts reads still in the memory pipeline plus words parked in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ReadLatency; i++) begin
      inflight = inflight + CW'(vld_p0[i]);
    end
  end

  assign credit_ok = (inflight + fifo_cnt) < CW'(FifoDepth);
  assign issue     = (state_q == S_ISSUE) && credit_ok;
  assign ce0       = issue;

  assign push      = vld_p0[ReadLatency-1];
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_data_p1[rd_ptr] : '0;
  assign out_last  = out_valid && fifo_last_p1[rd_ptr];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0)  state_d = S_DONE;
          else if (cmd_bad)   state_d = S_DONE;
          else                state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue && (rem_q == (AddressWidth+1)'(1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && out_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      vld_p0   <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
        err_q  <= (cmd_len != '0) && cmd_bad;
      end else if (issue) begin
        addr_q <= addr_next;
        rem_q  <= rem_q - 1'b1;
      end
      for (int i = ReadLatency - 1; i > 0; i--) begin
        vld_p0[i] <= vld_p0[i-1];
      end
      vld_p0[0] <= issue;
      if (push) wr_ptr <= (wr_ptr == PW'(FifoDepth - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FifoDepth - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Stage boundary: q0 capture into the output FIFO, last flag travels with the read.
  always_ff @(posedge clk) begin
    for (int i = ReadLatency - 1; i > 0; i--) begin
      last_p0[i] <= last_p0[i-1];
    end
    last_p0[0] <= (rem_q == (AddressWidth+1)'(1));
    if (push) begin
      fifo_data_p1[wr_ptr] <= q0;
      fifo_last_p1[wr_ptr] <= last_p0[ReadLatency-1];
    end
  end

endmodule

// File: tb/tb_knn_local_buf_scan_reader.sv
// Scoreboard bench for knn_local_buf_scan_reader with a behavioural buffer model (ReadLatency=2).
module tb_knn_local_buf_scan_reader;
  localparam int DW = 256;
  localparam int AR = 2048;
  localparam int AW = 11;
  localparam int RL = 2;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic [AW-1:0] address0;
  logic          ce0, we0;
  logic [DW-1:0] d0, q0;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic          busy, done, err;

  always #5 clk = ~clk;

  knn_local_buf_scan_reader #(
    .DataWidth(DW), .AddressRange(AR), .AddressWidth(AW), .ReadLatency(RL), .FifoDepth(FD)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .address0(address0), .ce0(ce0),
    .we0(we0), .d0(d0), .q0(q0), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [DW-1:0] mword(input int a);
    return {8{32'hC0DE_0000 + 32'(a)}};
  endfunction

  // Two-cycle buffer model; garbage on q0 whenever no read is landing.
  logic [DW-1:0] r1;
  logic          r1_v;
  always @(posedge clk) begin
    r1_v <= ce0;
    r1   <= mword(int'(address0));
    q0   <= r1_v ? r1 : {8{32'hDEAD_BEEF}};
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t sbq[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_expect(input int a, input int l);
    exp_t e;
    for (int i = 0; i < l; i++) begin
      int ad;
      ad = a + i;
      if (ad >= AR) ad = ad - AR;
      e.d = mword(ad);
      e.l = (i == l - 1);
      sbq.push_back(e);
    end
  endtask

  task automatic monitor();
    int issued = 0;
    int popped = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic prev_l = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        issued = 0;
        popped = 0;
        prev_stall = 1'b0;
        sbq.delete();
      end else begin
        if (prev_stall)
          chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_l, prev_d});
        if (ce0) begin
          chk("credit", 264'(issued - popped < FD), 264'(1));
          issued++;
        end
        if (out_valid && out_ready) begin
          chk("sb_nonempty", 264'(sbq.size() != 0), 264'(1));
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("data", out_data, e.d);
            chk("last", out_last, e.l);
          end
          popped++;
        end
        prev_stall = out_valid && !out_ready;
        prev_d = out_data;
        prev_l = out_last;
      end
    end
  endtask

  task automatic do_cmd(input int a, input int l);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_addr  = AW'(a);
    cmd_len   = (AW+1)'(l);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input logic exp_err, input int mode,
                           output int dcyc, output int nce, output int nov);
    bit seen;
    seen = 0; dcyc = 0; nce = 0; nov = 0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (ce0) nce++;
      if (out_valid) nov++;
      if (mode == 2 && k == 20) chk("stall_reads", 264'(nce), 264'(FD));
      if (done) begin
        seen = 1;
        dcyc = k;
        chk("err_flag", err, exp_err);
        break;
      end
      @(posedge clk);
      #1;
      case (mode)
        1:       out_ready = k[0];
        2:       out_ready = (k >= 20);
        default: out_ready = 1'b1;
      endcase
    end
    chk("done_seen", 264'(seen), 264'(1));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ctl"}, {cmd_ready, ce0, we0, out_valid, out_last, busy, done, err}, 264'(0));
    chk({nm, "_addr"}, address0, 264'(0));
    chk({nm, "_d0"}, d0, 264'(0));
    chk({nm, "_odata"}, out_data, 264'(0));
  endtask

  initial begin
    int dc, nce, nov;
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;
    fork
      monitor();
    join_none
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    // Basic scan: exact cycle pattern.
    out_ready = 1'b1;
    push_expect(0, 4);
    do_cmd(0, 4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t1_ce0", ce0, 264'(k <= 4));
      if (k <= 4) chk("t1_addr", address0, 264'(k - 1));
      chk("t1_valid", out_valid, 264'(k >= 4 && k <= 7));
      chk("t1_done", done, 264'(k == 8));
    end
    @(negedge clk);
    chk("t1_ready_after_done", {cmd_ready, done}, 264'(2'b10));

    // Toggling back-pressure.
    push_expect(10, 16);
    do_cmd(10, 16);
    wait_done(200, 1'b0, 1, dc, nce, nov);
    chk("t2_reads", 264'(nce), 264'(16));
    chk("t2_sb_empty", 264'(sbq.size()), 264'(0));

    // Long stall.
    out_ready = 1'b0;
    push_expect(200, 64);
    do_cmd(200, 64);
    wait_done(400, 1'b0, 2, dc, nce, nov);
    chk("t3_reads", 264'(nce), 264'(64));
    chk("t3_sb_empty", 264'(sbq.size()), 264'(0));

    // Range edge.
    out_ready = 1'b1;
`ifdef KNN_SCAN_WRAP_EN
    push_expect(2040, 16);
    do_cmd(2040, 16);
    wait_done(200, 1'b0, 0, dc, nce, nov);
    chk("t4_reads", 264'(nce), 264'(16));
    chk("t4_sb_empty", 264'(sbq.size()), 264'(0));
`else
    do_cmd(2040, 16);
    wait_done(10, 1'b1, 0, dc, nce, nov);
    chk("t4_done_cycle", 264'(dc), 264'(1));
    chk("t4_no_reads", 264'(nce), 264'(0));
`endif

    // Zero-length command.
    do_cmd(5, 0);
    wait_done(10, 1'b0, 0, dc, nce, nov);
    chk("t5_done_cycle", 264'(dc), 264'(1));
    chk("t5_no_reads", 264'(nce), 264'(0));
    chk("t5_no_valid", 264'(nov), 264'(0));

    // Reset with two reads in flight.
    push_expect(300, 8);
    do_cmd(300, 8);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("midreset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midreset_quiet", {out_valid, out_data}, 264'(0));
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_valid", {cmd_ready, out_valid, busy}, 264'(3'b100));
    push_expect(500, 5);
    do_cmd(500, 5);
    wait_done(100, 1'b0, 0, dc, nce, nov);
    chk("t6_reads", 264'(nce), 264'(5));
    chk("t6_sb_empty", 264'(sbq.size()), 264'(0));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
